// File: rtl/score_window_manager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | score_window_manager: NW score-matrix walker with saturating boundaries, |
// | double row buffer and write-through to the traceback RAM.   Rev 1.0      |
// +--------------------------------------------------------------------------+
module score_window_manager #(
  parameter int N     = 128,
  parameter int M     = 128,
  parameter int W     = 9,
  parameter int GAP   = -2,
  parameter int BitI  = $clog2(N+1),
  parameter int BitJ  = $clog2(M+1),
  parameter int AddrW = $clog2((N+1)*(M+1))
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] max,
  input  logic                max_valid,
  output logic signed [W-1:0] diag,
  output logic signed [W-1:0] up,
  output logic signed [W-1:0] left,
  output logic                nb_valid,
  output logic [BitI-1:0]     i_idx,
  output logic [BitJ-1:0]     j_idx,
  output logic                mem_we,
  output logic [AddrW-1:0]    mem_addr,
  output logic signed [W-1:0] mem_din,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT_ROW  = 3'd1,
    ROW_START = 3'd2,
    LOAD      = 3'd3,
    CELL      = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic signed [W+1:0] c_gap     = (W+2)'(GAP);
  localparam logic signed [W+1:0] c_sat_max = (W+2)'((2**(W-1)) - 1);
  localparam logic signed [W+1:0] c_sat_min = (W+2)'(-(2**(W-1)));
  localparam logic [AddrW-1:0]    c_row_len = AddrW'(M+1);
  localparam logic [BitJ-1:0]     c_j_last  = BitJ'(M);
  localparam logic [BitI-1:0]     c_i_last  = BitI'(N);

  // One accumulator step k*GAP -> (k+1)*GAP; clamping is sticky because GAP is constant.
  function automatic logic signed [W-1:0] sat_step(input logic signed [W-1:0] x);
    logic signed [W+1:0] s;
    s = (W+2)'(x) + c_gap;
    if (s > c_sat_max)      return c_sat_max[W-1:0];
    else if (s < c_sat_min) return c_sat_min[W-1:0];
    else                    return s[W-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [BitI-1:0]     i_q, i_d;
  logic [BitJ-1:0]     j_q, j_d;
  logic                sel_q, sel_d;
  logic signed [W-1:0] col_bnd_q, col_bnd_d;
  logic signed [W-1:0] row_bnd_q, row_bnd_d;
  logic [AddrW-1:0]    row_base_q, row_base_d;
  logic signed [W-1:0] left_q, left_d;
  logic signed [W-1:0] diag_q, diag_d;
  logic signed [W-1:0] up_q, up_d;
  logic                nb_valid_q, nb_valid_d;
  logic                we_q, we_d;
  logic [AddrW-1:0]    addr_q, addr_d;
  logic signed [W-1:0] din_q, din_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic signed [W-1:0] buf0_q [0:M];
  logic signed [W-1:0] buf1_q [0:M];
  logic                buf_we0, buf_we1;
  logic [BitJ-1:0]     buf_idx;
  logic signed [W-1:0] buf_wdata;
  logic [BitJ-1:0]     j_prev;
  logic signed [W-1:0] rd_diag, rd_up;

  // sel_q = 0: buf0 holds the previous row, buf1 collects the current row.
  assign j_prev  = j_q - BitJ'(1);
  assign rd_diag = sel_q ? buf1_q[j_prev] : buf0_q[j_prev];
  assign rd_up   = sel_q ? buf1_q[j_q]    : buf0_q[j_q];

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    sel_d      = sel_q;
    col_bnd_d  = col_bnd_q;
    row_bnd_d  = row_bnd_q;
    row_base_d = row_base_q;
    left_d     = left_q;
    diag_d     = diag_q;
    up_d       = up_q;
    nb_valid_d = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    done_d     = 1'b0;
    buf_we0    = 1'b0;
    buf_we1    = 1'b0;
    buf_idx    = j_q;
    buf_wdata  = col_bnd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = INIT_ROW;
          i_d        = '0;
          j_d        = '0;
          sel_d      = 1'b0;
          col_bnd_d  = '0;
          row_bnd_d  = '0;
          row_base_d = '0;
        end
      end
      INIT_ROW: begin
        buf_we0   = ~sel_q;
        buf_we1   = sel_q;
        we_d      = 1'b1;
        addr_d    = AddrW'(j_q);
        din_d     = col_bnd_q;
        col_bnd_d = sat_step(col_bnd_q);
        if (j_q == c_j_last) begin
          state_d    = ROW_START;
          i_d        = BitI'(1);
          j_d        = '0;
          row_base_d = c_row_len;
          row_bnd_d  = sat_step(row_bnd_q);
        end else begin
          j_d = j_q + BitJ'(1);
        end
      end
      ROW_START: begin
        // cur[0] feeds the diag of column 1 once this row becomes prev.
        buf_we0   = sel_q;
        buf_we1   = ~sel_q;
        buf_idx   = '0;
        buf_wdata = row_bnd_q;
        left_d    = row_bnd_q;
        we_d      = 1'b1;
        addr_d    = row_base_q;
        din_d     = row_bnd_q;
        j_d       = BitJ'(1);
        state_d   = LOAD;
      end
      LOAD: begin
        diag_d     = rd_diag;
        up_d       = rd_up;
        nb_valid_d = 1'b1;
        state_d    = CELL;
      end
      CELL: begin
        nb_valid_d = 1'b1;
        if (max_valid) begin
          buf_we0    = sel_q;
          buf_we1    = ~sel_q;
          buf_wdata  = max;
          left_d     = max;
          we_d       = 1'b1;
          addr_d     = row_base_q + AddrW'(j_q);
          din_d      = max;
          nb_valid_d = 1'b0;
          if (j_q != c_j_last) begin
            j_d     = j_q + BitJ'(1);
            state_d = LOAD;
          end else if (i_q != c_i_last) begin
            sel_d      = ~sel_q;
            i_d        = i_q + BitI'(1);
            j_d        = '0;
            row_base_d = row_base_q + c_row_len;
            row_bnd_d  = sat_step(row_bnd_q);
            state_d    = ROW_START;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      sel_q      <= 1'b0;
      col_bnd_q  <= '0;
      row_bnd_q  <= '0;
      row_base_q <= '0;
      left_q     <= '0;
      diag_q     <= '0;
      up_q       <= '0;
      nb_valid_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      sel_q      <= sel_d;
      col_bnd_q  <= col_bnd_d;
      row_bnd_q  <= row_bnd_d;
      row_base_q <= row_base_d;
      left_q     <= left_d;
      diag_q     <= diag_d;
      up_q       <= up_d;
      nb_valid_q <= nb_valid_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we0) buf0_q[buf_idx] <= buf_wdata;
    if (buf_we1) buf1_q[buf_idx] <= buf_wdata;
  end

  assign diag     = diag_q;
  assign up       = up_q;
  assign left     = left_q;
  assign nb_valid = nb_valid_q;
  assign i_idx    = i_q;
  assign j_idx    = j_q;
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_score_window_manager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_score_window_manager: scoreboard bench for score_window_manager.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_score_window_manager;

  localparam int NA = 2, MA = 2, WA = 9, GA = -2;
  localparam int IA = $clog2(NA+1), JA = $clog2(MA+1), AA = $clog2((NA+1)*(MA+1));
  localparam int NB = 1, MB = 3, WB = 4, GB = -3;
  localparam int IB = $clog2(NB+1), JB = $clog2(MB+1), AB = $clog2((NB+1)*(MB+1));

  typedef struct {int addr; int data;} wr_t;
  typedef struct {int i; int j; int d; int u; int l;} nb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 a_start = 1'b0, a_max_valid = 1'b0;
  logic signed [WA-1:0] a_max = '0;
  logic signed [WA-1:0] a_diag, a_up, a_left, a_mem_din;
  logic                 a_nb_valid, a_mem_we, a_busy, a_done;
  logic [IA-1:0]        a_i_idx;
  logic [JA-1:0]        a_j_idx;
  logic [AA-1:0]        a_mem_addr;

  logic                 b_start = 1'b0, b_max_valid = 1'b0;
  logic signed [WB-1:0] b_max = '0;
  logic signed [WB-1:0] b_diag, b_up, b_left, b_mem_din;
  logic                 b_nb_valid, b_mem_we, b_busy, b_done;
  logic [IB-1:0]        b_i_idx;
  logic [JB-1:0]        b_j_idx;
  logic [AB-1:0]        b_mem_addr;

  score_window_manager #(.N(NA), .M(MA), .W(WA), .GAP(GA)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .max(a_max), .max_valid(a_max_valid),
    .diag(a_diag), .up(a_up), .left(a_left), .nb_valid(a_nb_valid),
    .i_idx(a_i_idx), .j_idx(a_j_idx), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_din(a_mem_din), .busy(a_busy), .done(a_done));

  score_window_manager #(.N(NB), .M(MB), .W(WB), .GAP(GB)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .max(b_max), .max_valid(b_max_valid),
    .diag(b_diag), .up(b_up), .left(b_left), .nb_valid(b_nb_valid),
    .i_idx(b_i_idx), .j_idx(b_j_idx), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_din(b_mem_din), .busy(b_busy), .done(b_done));

  int  checks = 0, errors = 0;
  wr_t qa_wr[$], qb_wr[$];
  nb_t qa_nb[$];
  wr_t a_e, b_e;
  nb_t a_cur;
  bit  a_have = 1'b0, a_nb_prev = 1'b0;
  int  a_done_cnt = 0, b_done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // k*gap clamped to the signed range of a w-bit score
  function automatic int bnd(input int k, input int gap, input int w);
    int v  = k * gap;
    int hi = (1 << (w-1)) - 1;
    int lo = -(1 << (w-1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      a_nb_prev = 1'b0;
      a_have    = 1'b0;
    end else begin
      if (a_mem_we) begin
        if (qa_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_write: got addr %0d data %0d expected no write",
                   int'(a_mem_addr), int'(a_mem_din));
        end else begin
          a_e = qa_wr.pop_front();
          chk("a_wr_addr", int'(a_mem_addr), a_e.addr);
          chk("a_wr_data", int'(a_mem_din), a_e.data);
        end
      end
      if (a_nb_valid) begin
        if (!a_nb_prev) begin
          if (qa_nb.size() == 0) begin
            checks++; errors++; a_have = 1'b0;
            $display("FAIL a_unexpected_nb: got i %0d j %0d expected no cell",
                     int'(a_i_idx), int'(a_j_idx));
          end else begin
            a_cur  = qa_nb.pop_front();
            a_have = 1'b1;
          end
        end
        if (a_have) begin
          chk("a_nb_i", int'(a_i_idx), a_cur.i);
          chk("a_nb_j", int'(a_j_idx), a_cur.j);
          chk("a_nb_diag", int'(a_diag), a_cur.d);
          chk("a_nb_up", int'(a_up), a_cur.u);
          chk("a_nb_left", int'(a_left), a_cur.l);
        end
      end
      a_nb_prev = a_nb_valid;
      if (a_done) a_done_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_mem_we) begin
        if (qb_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_write: got addr %0d data %0d expected no write",
                   int'(b_mem_addr), int'(b_mem_din));
        end else begin
          b_e = qb_wr.pop_front();
          chk("b_wr_addr", int'(b_mem_addr), b_e.addr);
          chk("b_wr_data", int'(b_mem_din), b_e.data);
        end
      end
      if (b_done) b_done_cnt++;
    end
  end

  task automatic check_a_zero();
    chk("rst_diag", int'(a_diag), 0);
    chk("rst_up", int'(a_up), 0);
    chk("rst_left", int'(a_left), 0);
    chk("rst_nb_valid", int'(a_nb_valid), 0);
    chk("rst_i_idx", int'(a_i_idx), 0);
    chk("rst_j_idx", int'(a_j_idx), 0);
    chk("rst_mem_we", int'(a_mem_we), 0);
    chk("rst_mem_addr", int'(a_mem_addr), 0);
    chk("rst_mem_din", int'(a_mem_din), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
  endtask

  task automatic run_a(input bit directed, input bit do_abort);
    int mat [0:NA][0:MA];
    int k = 0, guard = 0, lat = 0, stall = 0, ci, cj;
    int dvals [4] = '{1, 2, -1, 3};
    for (int i = 0; i <= NA; i++)
      for (int j = 0; j <= MA; j++)
        if (i == 0)      mat[i][j] = bnd(j, GA, WA);
        else if (j == 0) mat[i][j] = bnd(i, GA, WA);
        else if (directed) mat[i][j] = dvals[(i-1)*MA + (j-1)];
        else             mat[i][j] = int'($urandom_range(0, 511)) - 256;
    for (int j = 0; j <= MA; j++) qa_wr.push_back(wr_t'{j, mat[0][j]});
    qa_wr.push_back(wr_t'{MA+1, mat[1][0]});
    for (int i = 1; i <= NA; i++)
      for (int j = 1; j <= MA; j++)
        qa_nb.push_back(nb_t'{i, j, mat[i-1][j-1], mat[i-1][j], mat[i][j-1]});
    a_done_cnt = 0;

    @(negedge clk); a_start = 1'b1;
    while (lat < 50) begin
      @(negedge clk); a_start = 1'b0; lat++;
      if (a_nb_valid) break;
    end
    chk("a_first_nb_latency", lat, MA + 4);

    while (k < NA*MA && guard < 2000) begin
      @(negedge clk); guard++;
      a_max_valid = 1'b0; a_start = 1'b0;
      if (a_nb_valid) begin
        if (stall > 0) stall--;
        else begin
          ci = k / MA + 1; cj = k % MA + 1;
          if (do_abort && ci == 1 && cj == 2) begin
            rst = 1'b1;
            @(posedge clk); #1;
            check_a_zero();
            rst = 1'b0;
            qa_wr.delete(); qa_nb.delete(); a_done_cnt = 0;
            repeat (6) @(negedge clk);
            chk("a_abort_no_done", a_done_cnt, 0);
            chk("a_abort_idle", int'(a_busy), 0);
            return;
          end
          a_max_valid = 1'b1;
          a_max = WA'(mat[ci][cj]);
          qa_wr.push_back(wr_t'{ci*(MA+1) + cj, mat[ci][cj]});
          if (cj == MA && ci < NA) qa_wr.push_back(wr_t'{(ci+1)*(MA+1), mat[ci+1][0]});
          k++;
          stall = (k == 2) ? 5 : int'($urandom_range(0, 3));
        end
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          a_max_valid = 1'b1;
          a_max = WA'(int'($urandom_range(0, 511)) - 256);
        end
        if ($urandom_range(0, 3) == 0) a_start = 1'b1;
      end
    end
    if (guard >= 2000) begin
      checks++; errors++;
      $display("FAIL a_timeout: got %0d cells expected %0d", k, NA*MA);
    end
    @(negedge clk); a_max_valid = 1'b0; a_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("a_done_pulses", a_done_cnt, 1);
    chk("a_busy_after", int'(a_busy), 0);
    chk("a_final_i", int'(a_i_idx), NA);
    chk("a_final_j", int'(a_j_idx), MA);
    chk("a_wr_left", qa_wr.size(), 0);
    chk("a_nb_left", qa_nb.size(), 0);
  endtask

  task automatic run_b();
    int k = 0, guard = 0, v, ci, cj;
    for (int j = 0; j <= MB; j++) qb_wr.push_back(wr_t'{j, bnd(j, GB, WB)});
    qb_wr.push_back(wr_t'{MB+1, bnd(1, GB, WB)});
    b_done_cnt = 0;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    while (k < NB*MB && guard < 500) begin
      @(negedge clk); guard++;
      b_max_valid = 1'b0;
      if (b_nb_valid && $urandom_range(0, 1) == 1) begin
        ci = k / MB + 1; cj = k % MB + 1;
        v  = int'($urandom_range(0, 15)) - 8;
        b_max_valid = 1'b1;
        b_max = WB'(v);
        qb_wr.push_back(wr_t'{ci*(MB+1) + cj, v});
        if (cj == MB && ci < NB) qb_wr.push_back(wr_t'{(ci+1)*(MB+1), bnd(ci+1, GB, WB)});
        k++;
      end
    end
    if (guard >= 500) begin
      checks++; errors++;
      $display("FAIL b_timeout: got %0d cells expected %0d", k, NB*MB);
    end
    @(negedge clk); b_max_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("b_done_pulses", b_done_cnt, 1);
    chk("b_busy_after", int'(b_busy), 0);
    chk("b_wr_left", qb_wr.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_a_zero();
    @(negedge clk); rst = 1'b0;
    run_a(1'b1, 1'b0);
    run_a(1'b0, 1'b1);
    for (int r = 0; r < 4; r++) run_a(1'b0, 1'b0);
    run_b();
    run_b();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
